// File: rtl/b_lut_inv_pkg.sv
// Shared constants for the LUT inverter: state encoding, table geometry, latency.
package b_lut_inv_pkg;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int ENTRY_W = 4;
   localparam int ENTRY_N = 16;
   localparam int TABLE_W = ENTRY_W * ENTRY_N;
   localparam int LATENCY = 17;
endpackage

// File: rtl/b_lut_inv.sv
// Inverts a 16-entry 4-bit forward LUT (inv[fwd[i]] = i) and flags whether it was a bijection.
// Latency: ready pulses 17 cycles after the cycle valid is presented in IDLE (16 BUSY + 1 DONE).
// Backpressure: none; valid is ignored while BUSY/DONE and flush aborts to IDLE without ready.
module b_lut_inv
   import b_lut_inv_pkg::*;
(
   input  logic        g_clk,
   input  logic        g_reset,
   input  logic        flush,
   input  logic        valid,
   input  logic [31:0] crs2,
   input  logic [31:0] crs3,
   output logic        ready,
   output logic [31:0] result_lo,
   output logic [31:0] result_hi,
   output logic        perm_ok
);

   state_t               state;
   logic [ENTRY_W-1:0]   cnt;
   logic [TABLE_W-1:0]   op;
   logic [TABLE_W-1:0]   inv;
   logic [ENTRY_N-1:0]   mask;
   logic                 dup;

   logic [ENTRY_W-1:0]   fwd;
   logic [TABLE_W-1:0]   inv_nxt;
   logic [ENTRY_N-1:0]   mask_set;
   logic                 dup_nxt;

   function automatic logic [ENTRY_W-1:0] nib(input logic [TABLE_W-1:0] t,
                                              input logic [ENTRY_W-1:0] i);
      return t[{i, 2'b00} +: ENTRY_W];
   endfunction

   // Next-state view of the table after processing entry cnt; the last BUSY
   // cycle publishes this directly so entry 15 is included in the result.
   always_comb begin
      fwd      = nib(op, cnt);
      inv_nxt  = inv;
      inv_nxt[{fwd, 2'b00} +: ENTRY_W] = cnt;
      mask_set = ENTRY_N'(1) << fwd;
      dup_nxt  = dup | mask[fwd];
   end

   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         op        <= '0;
         inv       <= '0;
         mask      <= '0;
         dup       <= 1'b0;
         ready     <= 1'b0;
         result_lo <= '0;
         result_hi <= '0;
         perm_ok   <= 1'b0;
      end else begin
         ready     <= 1'b0;
         result_lo <= '0;
         result_hi <= '0;
         perm_ok   <= 1'b0;
         if (flush) begin
            state <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (valid) begin
                     op    <= {crs3, crs2};
                     inv   <= '0;
                     mask  <= '0;
                     dup   <= 1'b0;
                     cnt   <= '0;
                     state <= ST_BUSY;
                  end
               end
               ST_BUSY: begin
                  inv  <= inv_nxt;
                  mask <= mask | mask_set;
                  dup  <= dup_nxt;
                  // Counter holds at 15 on exit so it never wraps into a 17th write.
                  if (cnt == 4'hF) begin
                     state     <= ST_DONE;
                     ready     <= 1'b1;
                     result_lo <= inv_nxt[31:0];
                     result_hi <= inv_nxt[63:32];
                     perm_ok   <= ~dup_nxt;
                  end else begin
                     cnt <= cnt + 4'd1;
                  end
               end
               ST_DONE: state <= ST_IDLE;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_b_lut_inv.sv
// Directed bench for b_lut_inv: known LUTs with hand-computed inverses, flush, reset and back-to-back timing.
module tb_b_lut_inv;

   logic        g_clk;
   logic        g_reset;
   logic        flush;
   logic        valid;
   logic [31:0] crs2;
   logic [31:0] crs3;
   logic        ready;
   logic [31:0] result_lo;
   logic [31:0] result_hi;
   logic        perm_ok;

   int checks   = 0;
   int failures = 0;

   b_lut_inv dut (
      .g_clk     (g_clk),
      .g_reset   (g_reset),
      .flush     (flush),
      .valid     (valid),
      .crs2      (crs2),
      .crs3      (crs3),
      .ready     (ready),
      .result_lo (result_lo),
      .result_hi (result_hi),
      .perm_ok   (perm_ok)
   );

   initial begin
      g_clk = 1'b0;
      forever #5 g_clk = ~g_clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present one request in an IDLE cycle (cycle 0) and expect ready in cycle 17.
   task automatic run_op(input logic [31:0] c2, input logic [31:0] c3,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                         input logic exp_ok, input string tag);
      int  n;
      bit  got;
      n   = 0;
      got = 1'b0;
      @(negedge g_clk);
      valid = 1'b1;
      crs2  = c2;
      crs3  = c3;
      for (int k = 1; k <= 40 && !got; k++) begin
         @(negedge g_clk);
         if (k == 1) begin
            crs2 = $urandom;
            crs3 = $urandom;
         end
         if (k == 8) begin
            chk({tag, "_busy_ready"}, {31'd0, ready}, 32'd0);
            chk({tag, "_busy_lo"}, result_lo, 32'd0);
         end
         if (ready) begin
            got = 1'b1;
            n   = k;
         end
      end
      chk({tag, "_latency"}, n, 32'd17);
      chk({tag, "_lo"}, result_lo, exp_lo);
      chk({tag, "_hi"}, result_hi, exp_hi);
      chk({tag, "_perm_ok"}, {31'd0, perm_ok}, {31'd0, exp_ok});
      valid = 1'b0;
      @(negedge g_clk);
      chk({tag, "_after_ready"}, {31'd0, ready}, 32'd0);
      chk({tag, "_after_lo"}, result_lo, 32'd0);
      chk({tag, "_after_perm_ok"}, {31'd0, perm_ok}, 32'd0);
   endtask

   initial begin
      int nrdy;
      int t_rdy[3];
      int idx;

      g_reset = 1'b1;
      flush   = 1'b0;
      valid   = 1'b0;
      crs2    = '0;
      crs3    = '0;
      #1;
      chk("reset_ready", {31'd0, ready}, 32'd0);
      chk("reset_lo", result_lo, 32'd0);
      chk("reset_hi", result_hi, 32'd0);
      chk("reset_perm_ok", {31'd0, perm_ok}, 32'd0);
      @(negedge g_clk);
      @(negedge g_clk);
      g_reset = 1'b0;

      run_op(32'h76543210, 32'hFEDCBA98, 32'h76543210, 32'hFEDCBA98, 1'b1, "identity");
      run_op(32'h89ABCDEF, 32'h01234567, 32'h89ABCDEF, 32'h01234567, 1'b1, "reversal");
      run_op(32'h00000000, 32'h00000000, 32'h0000000F, 32'h00000000, 1'b0, "all_zero");
      run_op(32'h87654321, 32'h0FEDCBA9, 32'h6543210F, 32'hEDCBA987, 1'b1, "rotate1");

      // Flush in BUSY cycle 8 must kill the operation.
      @(negedge g_clk);
      valid = 1'b1;
      crs2  = 32'h76543210;
      crs3  = 32'hFEDCBA98;
      for (int k = 1; k <= 8; k++) @(negedge g_clk);
      flush = 1'b1;
      valid = 1'b0;
      @(negedge g_clk);
      flush = 1'b0;
      nrdy  = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge g_clk);
         if (ready) nrdy++;
      end
      chk("flush_no_ready", nrdy, 32'd0);
      run_op(32'h76543210, 32'hFEDCBA98, 32'h76543210, 32'hFEDCBA98, 1'b1, "post_flush");

      // Reset in BUSY cycle 5 discards the operation.
      @(negedge g_clk);
      valid = 1'b1;
      for (int k = 1; k <= 5; k++) @(negedge g_clk);
      g_reset = 1'b1;
      valid   = 1'b0;
      #1;
      chk("rst_busy_ready", {31'd0, ready}, 32'd0);
      chk("rst_busy_lo", result_lo, 32'd0);
      @(negedge g_clk);
      g_reset = 1'b0;
      nrdy = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge g_clk);
         if (ready) nrdy++;
      end
      chk("rst_no_ready", nrdy, 32'd0);

      // Reset during the DONE cycle clears outputs without waiting for a clock.
      @(negedge g_clk);
      valid = 1'b1;
      crs2  = 32'h76543210;
      crs3  = 32'hFEDCBA98;
      nrdy  = 0;
      for (int k = 1; k <= 40 && nrdy == 0; k++) begin
         @(negedge g_clk);
         if (ready) nrdy = k;
      end
      chk("done_seen_latency", nrdy, 32'd17);
      valid   = 1'b0;
      g_reset = 1'b1;
      #1;
      chk("rst_done_ready", {31'd0, ready}, 32'd0);
      chk("rst_done_lo", result_lo, 32'd0);
      chk("rst_done_hi", result_hi, 32'd0);
      @(negedge g_clk);
      g_reset = 1'b0;

      // Valid held high: ready every 18 cycles.
      @(negedge g_clk);
      valid = 1'b1;
      crs2  = 32'h89ABCDEF;
      crs3  = 32'h01234567;
      idx   = 0;
      t_rdy = '{0, 0, 0};
      for (int k = 1; k <= 80 && idx < 3; k++) begin
         @(negedge g_clk);
         if (ready) begin
            t_rdy[idx] = k;
            chk("b2b_lo", result_lo, 32'h89ABCDEF);
            idx++;
            if (idx == 3) valid = 1'b0;
         end
      end
      chk("b2b_first", t_rdy[0], 32'd17);
      chk("b2b_second", t_rdy[1], 32'd35);
      chk("b2b_third", t_rdy[2], 32'd53);
      nrdy = 0;
      for (int k = 0; k < 25; k++) begin
         @(negedge g_clk);
         if (ready) nrdy++;
      end
      chk("b2b_stops", nrdy, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/b_lut_inv.md
B_LUT_INV -- requirements
Module: b_lut_inv

Interface
REQ-001 Clock/reset SHALL be: one clock; reset is asynchronous and active-high.
REQ-002 g_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 g_reset  input  1  asynchronous, active-high reset.
REQ-004 flush  input  1  abort any in-progress operation.
REQ-005 valid  input  1  request; held high by requester until ready seen.
REQ-006 crs2  input  32  forward LUT entries 0-7; entry i is crs2[4i+3:4i].
REQ-007 crs3  input  32  forward LUT entries 8-15; entry i is crs3[4(i-8)+3:4(i-8)].
REQ-008 ready  output  1  one-cycle pulse: results valid this cycle.
REQ-009 result_lo  output  32  inverse LUT entries 0-7, same nibble packing as crs2.
REQ-010 result_hi  output  32  inverse LUT entries 8-15, same nibble packing as crs3.
REQ-011 perm_ok  output  1  forward LUT was a bijection on 4-bit values; valid only with ready.

Function
REQ-012 Purpose: build inverse table such that inv[fwd[i]] = i for every i, turning a forward xc.lut table into its inverse.
REQ-013 FSM states: IDLE, BUSY, DONE.
REQ-014 IDLE: on valid=1 capture crs2/crs3 into a 64-bit operand register, clear inverse table, clear written mask and dup flag, zero index counter, go BUSY.
REQ-015 BUSY: one entry per cycle; index i = counter value 0..15; write inv[fwd[i]] <= i; set mask bit fwd[i]; if mask bit already set, set dup flag.
REQ-016 BUSY exits to DONE after the cycle processing i=15; 4-bit counter SHALL NOT wrap into a 17th write.
REQ-017 Later writes to the same inverse entry overwrite earlier ones (highest i wins).
REQ-018 Entries never written SHALL read 0.
REQ-019 DONE: ready=1 for exactly one cycle; result_lo/result_hi driven from inverse table; perm_ok = ~dup (equivalently mask all ones); next state IDLE unconditionally.
REQ-020 Latency: valid accepted at edge N -> ready high during cycle N+17 (16 BUSY cycles + 1 DONE).
REQ-021 valid still high in the IDLE cycle after DONE SHALL start a new operation; requester drops valid on ready.
REQ-022 valid ignored in BUSY and DONE; operands changing during BUSY do not affect result.
REQ-023 flush=1 in any state: next state IDLE, ready not asserted; flush has priority over valid and over DONE.
REQ-024 result_lo/result_hi/perm_ok SHALL be 0 whenever ready=0.

Reset
REQ-025 g_reset=1 asynchronously forces IDLE, counter 0, table 0, mask 0, dup 0; ready=0, result_lo=0, result_hi=0, perm_ok=0.
REQ-026 Reset mid-BUSY discards operation; no ready pulse follows reset deassertion without a new valid.

Structure
REQ-027 Shared package holds state encoding constants (IDLE/BUSY/DONE), LUT entry width (4), entry count (16), and latency constant (17).
REQ-028 Single flat module; no sub-module needed. Nibble select/write-decode may be a function inside it.

Verification
REQ-029 Identity: crs2=0x76543210, crs3=0xFEDCBA98 -> after 17 cycles ready=1, result_lo=0x76543210, result_hi=0xFEDCBA98, perm_ok=1.
REQ-030 Reversal: crs2=0x89ABCDEF, crs3=0x01234567 -> result_lo=0x89ABCDEF, result_hi=0x01234567, perm_ok=1.
REQ-031 Non-bijective: crs2=0, crs3=0 -> result_lo=0x0000000F, result_hi=0, perm_ok=0.
REQ-032 Rotate-by-1 (fwd[i]=i+1 mod 16): crs2=0x87654321, crs3=0x0FEDCBA9 -> result_lo=0x6543210F, result_hi=0xEDCBA987, perm_ok=1.
REQ-033 Flush at BUSY cycle 8 -> no ready within 40 cycles; new valid with identity LUT then completes correctly in 17 cycles.
REQ-034 g_reset pulse at BUSY cycle 5 -> all outputs 0 immediately, no ready afterwards; valid held continuously -> back-to-back ops give ready every 18 cycles.
